// File: rtl/enc_pkg.sv
// Shared constants, FSM encoding and byte-level helpers for the encrypt sequencer.
// Holds the tap table, memory map, preamble limits and the cipher byte encoder.
package enc_pkg;

    localparam int TAP_N = 9;
    localparam logic [6:0] TAP_TABLE [TAP_N] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };

    localparam logic [7:0] ADDR_PRE      = 8'd61;
    localparam logic [7:0] ADDR_PTN      = 8'd62;
    localparam logic [7:0] ADDR_INIT     = 8'd63;
    localparam logic [7:0] ADDR_OUT_BASE = 8'd64;

    localparam logic [7:0] MSG_MAX  = 8'd54;
    localparam logic [7:0] PRE_MIN  = 8'd10;
    localparam logic [7:0] PRE_MAX  = 8'd26;
    localparam logic [7:0] PAD_BYTE = 8'h20;
    localparam logic [5:0] LAST_IDX = 6'd63;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_PRE,
        S_CAP_PRE,
        S_RD_PTN,
        S_CAP_PTN,
        S_RD_INIT,
        S_CAP_INIT,
        S_FETCH,
        S_CAPT,
        S_WRITE,
        S_DONE
    } enc_state_t;

    function automatic logic [7:0] clamp_pre(input logic [7:0] b);
        if (b < PRE_MIN) return PRE_MIN;
        if (b > PRE_MAX) return PRE_MAX;
        return b;
    endfunction

    // Pattern byte 8 is the only way to reach the ninth table entry.
    function automatic logic [6:0] tap_sel(input logic [7:0] p);
        logic [3:0] idx;
        idx = (p == 8'd8) ? 4'd8 : {1'b0, p[2:0]};
        return TAP_TABLE[idx];
    endfunction

    function automatic logic [6:0] seed_from(input logic [6:0] b);
        return (b == 7'd0) ? 7'h01 : b;
    endfunction

    // Bit 7 of the message is dropped and replaced by parity of the ciphertext.
    function automatic logic [7:0] encode(input logic [6:0] m, input logic [6:0] key);
        logic [6:0] c;
        c = m ^ key;
        return {^c, c};
    endfunction

endpackage

// File: rtl/lfsr7_step.sv
// One step of the 7-bit Galois-free shift LFSR: shift left, feed back tap parity.
// Purely combinational, zero latency.
module lfsr7_step (
    input  logic [6:0] i_state,
    input  logic [6:0] i_taps,
    output logic [6:0] o_next
);

    assign o_next = {i_state[5:0], ^(i_state & i_taps)};

endmodule

// File: rtl/encrypt_sequencer.sv
// Reads preamble/pattern/seed, then streams 64 encrypted bytes into memory 64..127.
// Read byte = 3 cycles, pad byte = 1 cycle; any un-granted request stalls with outputs held.
module encrypt_sequencer
    import enc_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    output logic       o_ack,
    output logic       o_mem_req,
    input  logic       i_mem_gnt,
    output logic [7:0] o_mem_addr,
    output logic       o_mem_we,
    output logic [7:0] o_mem_wdata,
    input  logic [7:0] i_mem_rdata,
    output logic       o_busy
);

    enc_state_t r_state;
    logic       r_start_d;
    logic       r_ack;
    logic       r_busy;
    logic       r_mem_req;
    logic       r_mem_we;
    logic [7:0] r_mem_addr;
    logic [7:0] r_mem_wdata;
    logic [6:0] r_lfsr;
    logic [6:0] r_taps;
    logic [7:0] r_pre;
    logic [5:0] r_i;

    logic [6:0] w_lfsr_next;
    logic [6:0] w_seed;
    logic [5:0] w_entry_idx;
    logic [6:0] w_entry_lfsr;
    logic [7:0] w_entry_pos;
    logic [7:0] w_entry_k;
    logic       w_entry_is_msg;
    logic [7:0] w_entry_out_addr;
    logic [7:0] w_pad_c;

    lfsr7_step u_lfsr7_step (
        .i_state (r_lfsr),
        .i_taps  (r_taps),
        .o_next  (w_lfsr_next)
    );

    assign w_seed = seed_from(i_mem_rdata[6:0]);

    // Set-up for the byte about to start: byte 0 after the seed load, else i+1 after a write.
    assign w_entry_idx      = (r_state == S_CAP_INIT) ? 6'd0 : (r_i + 6'd1);
    assign w_entry_lfsr     = (r_state == S_CAP_INIT) ? w_seed : w_lfsr_next;
    assign w_entry_pos      = {2'b00, w_entry_idx};
    assign w_entry_k        = w_entry_pos - r_pre;
    assign w_entry_is_msg   = (w_entry_pos >= r_pre) && (w_entry_k < MSG_MAX);
    assign w_entry_out_addr = ADDR_OUT_BASE + w_entry_pos;
    assign w_pad_c          = encode(PAD_BYTE[6:0], w_entry_lfsr);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_start_d   <= 1'b0;
            r_ack       <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 8'd0;
            r_mem_wdata <= 8'd0;
            r_lfsr      <= 7'h01;
            r_taps      <= TAP_TABLE[0];
            r_pre       <= PRE_MIN;
            r_i         <= 6'd0;
        end else begin
            r_start_d <= i_start;
            case (r_state)
                S_IDLE: begin
                    if (r_start_d && !i_start) begin
                        r_state    <= S_RD_PRE;
                        r_busy     <= 1'b1;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= ADDR_PRE;
                        r_i        <= 6'd0;
                    end
                end
                S_RD_PRE: begin
                    if (i_mem_gnt) begin
                        r_state   <= S_CAP_PRE;
                        r_mem_req <= 1'b0;
                    end
                end
                S_CAP_PRE: begin
                    r_pre      <= clamp_pre(i_mem_rdata);
                    r_state    <= S_RD_PTN;
                    r_mem_req  <= 1'b1;
                    r_mem_addr <= ADDR_PTN;
                end
                S_RD_PTN: begin
                    if (i_mem_gnt) begin
                        r_state   <= S_CAP_PTN;
                        r_mem_req <= 1'b0;
                    end
                end
                S_CAP_PTN: begin
                    r_taps     <= tap_sel(i_mem_rdata);
                    r_state    <= S_RD_INIT;
                    r_mem_req  <= 1'b1;
                    r_mem_addr <= ADDR_INIT;
                end
                S_RD_INIT: begin
                    if (i_mem_gnt) begin
                        r_state   <= S_CAP_INIT;
                        r_mem_req <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (i_mem_gnt) begin
                        r_state   <= S_CAPT;
                        r_mem_req <= 1'b0;
                    end
                end
                S_CAPT: begin
                    r_mem_wdata <= encode(i_mem_rdata[6:0], r_lfsr);
                    r_mem_addr  <= ADDR_OUT_BASE + {2'b00, r_i};
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= 1'b1;
                    r_state     <= S_WRITE;
                end
                S_DONE: begin
                    if (i_start) begin
                        r_state <= S_IDLE;
                        r_ack   <= 1'b0;
                    end
                end
                S_CAP_INIT, S_WRITE: begin
                    if (r_state == S_CAP_INIT || i_mem_gnt) begin
                        r_lfsr <= w_entry_lfsr;
                        if (r_state == S_WRITE && r_i == LAST_IDX) begin
                            r_state   <= S_DONE;
                            r_mem_req <= 1'b0;
                            r_mem_we  <= 1'b0;
                            r_busy    <= 1'b0;
                            r_ack     <= 1'b1;
                        end else begin
                            r_i       <= w_entry_idx;
                            r_mem_req <= 1'b1;
                            if (w_entry_is_msg) begin
                                r_state    <= S_FETCH;
                                r_mem_we   <= 1'b0;
                                r_mem_addr <= w_entry_k;
                            end else begin
                                r_state     <= S_WRITE;
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= w_entry_out_addr;
                                r_mem_wdata <= w_pad_c;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ack       = r_ack;
    assign o_busy      = r_busy;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_encrypt_sequencer.sv
// Scoreboard bench: a memory responder serves the DUT, a model predicts every access,
// and a monitor pops and compares each accepted transfer.
module tb_encrypt_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b1;
    logic       gnt = 1'b0;
    logic [7:0] rdata = 8'd0;
    logic       ack, req, we, busy;
    logic [7:0] addr, wdata;

    encrypt_sequencer dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .o_ack       (ack),
        .o_mem_req   (req),
        .i_mem_gnt   (gnt),
        .o_mem_addr  (addr),
        .o_mem_we    (we),
        .o_mem_wdata (wdata),
        .i_mem_rdata (rdata),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int gap;
    } wr_t;

    wr_t        exp_wr[$];
    int         exp_rd[$];
    logic [7:0] mem [0:127];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         last_wr_cyc = 0;
    int         wr_seen = 0;
    bit         gnt_always = 1'b1;
    bit         pend_rd = 1'b0;
    logic [7:0] pend_addr = 8'd0;

    int taps_tbl [9] = '{'h60, 'h48, 'h78, 'h72, 'h6A, 'h69, 'h5C, 'h7E, 'h7B};

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input int act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got 0x%0h expected none (t=%0t)", name, act, $time);
    endtask

    // Reference: the whole run derived from memory contents with plain integer arithmetic.
    task automatic model_push();
        int pre, p, taps, lfsr, k, m, c7, c, gap;
        bit is_rd;
        pre = mem[61];
        if (pre < 10) pre = 10;
        if (pre > 26) pre = 26;
        p    = mem[62];
        taps = taps_tbl[(p == 8) ? 8 : (p % 8)];
        lfsr = mem[63] % 128;
        if (lfsr == 0) lfsr = 1;
        exp_rd.push_back(61);
        exp_rd.push_back(62);
        exp_rd.push_back(63);
        for (int i = 0; i < 64; i++) begin
            k     = i - pre;
            is_rd = (k >= 0) && (k < 54);
            if (is_rd) begin
                m = mem[k];
                exp_rd.push_back(k);
            end else begin
                m = 32;
            end
            c7  = (m % 128) ^ lfsr;
            c   = c7 + 128 * ($countones(c7) % 2);
            gap = (gnt_always && i > 0) ? (is_rd ? 3 : 1) : 0;
            exp_wr.push_back('{64 + i, c, gap});
            lfsr = ((lfsr * 2) % 128) + ($countones(lfsr & taps) % 2);
        end
    endtask

    // Memory responder: read data appears only in the cycle after the accepted read.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend_rd = 1'b0;
                gnt     = 1'b0;
                rdata   = 8'd0;
            end else begin
                rdata   = pend_rd ? mem[pend_addr[6:0]] : 8'($urandom);
                pend_rd = 1'b0;
                gnt     = gnt_always ? 1'b1 : 1'($urandom_range(0, 1));
                if (req && gnt && !we) begin
                    pend_rd   = 1'b1;
                    pend_addr = addr;
                end
                if (req && gnt && we) mem[addr[6:0]] = wdata;
            end
        end
    end

    // Monitor: pops expectations on each accepted transfer, checks holds during stalls.
    initial begin
        bit          prev_stall;
        logic [17:0] prev_vec;
        wr_t         e;
        int          ra;
        prev_stall = 1'b0;
        prev_vec   = '0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (rst_n) begin
                if (prev_stall) chk("stall_hold", int'({req, we, addr, wdata}), int'(prev_vec));
                if (req) chk("busy_during_access", int'(busy), 1);
                if (req && gnt) begin
                    if (we) begin
                        wr_seen++;
                        if (exp_wr.size() == 0) begin
                            fail_now("unexpected_write", int'(addr));
                        end else begin
                            e = exp_wr.pop_front();
                            chk("write_addr", int'(addr), e.addr);
                            chk("write_data", int'(wdata), e.data);
                            if (e.gap != 0) chk("byte_cycles", cyc - last_wr_cyc, e.gap);
                        end
                        last_wr_cyc = cyc;
                    end else begin
                        if (exp_rd.size() == 0) begin
                            fail_now("unexpected_read", int'(addr));
                        end else begin
                            ra = exp_rd.pop_front();
                            chk("read_addr", int'(addr), ra);
                        end
                    end
                end
                prev_stall = req && !gnt;
                prev_vec   = {req, we, addr, wdata};
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic fill_random();
        for (int a = 0; a < 128; a++) mem[a] = 8'($urandom);
    endtask

    task automatic launch();
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_run(input bit stall, input bit toggle, input int hold);
        gnt_always = !stall;
        model_push();
        launch();
        for (int t = 0; t < 3000 && !ack; t++) begin
            @(negedge clk);
            #2;
            if (toggle && t == 20) start = 1'b1;
            if (toggle && t == 22) start = 1'b0;
        end
        chk("ack_rise", int'(ack), 1);
        chk("busy_in_done", int'(busy), 0);
        chk("writes_left", exp_wr.size(), 0);
        chk("reads_left", exp_rd.size(), 0);
        exp_wr.delete();
        exp_rd.delete();
        repeat (hold) @(negedge clk);
        #2;
        chk("ack_hold", int'(ack), 1);
        start = 1'b1;
        @(negedge clk);
        #2;
        chk("ack_clear", int'(ack), 0);
        chk("busy_idle", int'(busy), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"}, int'(ack), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_req"}, int'(req), 0);
        chk({tag, "_we"}, int'(we), 0);
        chk({tag, "_addr"}, int'(addr), 0);
        chk({tag, "_wdata"}, int'(wdata), 0);
    endtask

    initial begin
        int base;
        fill_random();
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Scenario 1: all-space message, known seed.
        for (int a = 0; a < 61; a++) mem[a] = 8'h20;
        mem[61] = 8'd10; mem[62] = 8'd0; mem[63] = 8'h01;
        mem[64] = 8'h00; mem[65] = 8'h00;
        do_run(1'b0, 1'b0, 3);
        chk("dm64", int'(mem[64]), 'h21);
        chk("dm65", int'(mem[65]), 'h22);

        // Scenario 2: preamble clamping at both ends.
        fill_random(); mem[61] = 8'd3;
        do_run(1'b0, 1'b0, 2);
        fill_random(); mem[61] = 8'd40;
        do_run(1'b0, 1'b0, 2);

        // Scenario 3: tap index 8, masked index, zero seed.
        fill_random(); mem[62] = 8'd8;
        do_run(1'b0, 1'b0, 1);
        fill_random(); mem[62] = 8'h0D; mem[63] = 8'h00;
        do_run(1'b0, 1'b0, 1);
        fill_random(); mem[63] = 8'h80;
        do_run(1'b0, 1'b0, 1);

        // Scenario 4: random grant stalls plus an ignored Start toggle mid-run.
        fill_random();
        do_run(1'b1, 1'b1, 2);

        // Scenario 5: reset mid-run, then a clean run.
        fill_random();
        gnt_always = 1'b0;
        model_push();
        base = wr_seen;
        launch();
        for (int t = 0; t < 3000 && wr_seen < base + 20; t++) begin
            @(negedge clk);
            #2;
        end
        chk("reached_byte20", int'(wr_seen >= base + 20), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrun_reset");
        exp_wr.delete();
        exp_rd.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        chk("no_relaunch_busy", int'(busy), 0);
        chk("no_relaunch_req", int'(req), 0);
        fill_random();
        do_run(1'b0, 1'b0, 1);

        // Scenario 6: "Ajok" with maximum preamble under stalls, long Ack hold.
        fill_random();
        mem[0] = 8'h41; mem[1] = 8'h6A; mem[2] = 8'h6F; mem[3] = 8'h6B;
        mem[61] = 8'd26;
        do_run(1'b1, 1'b0, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/encrypt_sequencer.md
ENCRYPT_SEQUENCER -- requirements
Module: encrypt_sequencer

Interface
REQ-001 Clk  input  1  rising-edge clock for all state.
REQ-002 Reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-003 Start  input  1  level request; high holds the block idle, and a high-to-low transition launches one encryption run.
REQ-004 Ack  output  1  run complete.
REQ-005 Mem_Req  output  1  data-memory access request.
REQ-006 Mem_Gnt  input  1  memory port granted this cycle (port shared with CPU).
REQ-007 Mem_Addr  output  8  data-memory byte address.
REQ-008 Mem_We  output  1  write enable, qualified by Mem_Req.
REQ-009 Mem_WData  output  8  write data.
REQ-010 Mem_RData  input  8  read data, valid the cycle after an accepted read.
REQ-011 Busy  output  1  high in every state except IDLE and DONE.

Function
REQ-012 A transfer SHALL be accepted in any cycle where Mem_Req=1 and Mem_Gnt=1. While Mem_Gnt=0, Mem_Req, Mem_Addr, Mem_We and Mem_WData SHALL hold stable and the FSM SHALL stall.
REQ-013 FSM states SHALL be:
- IDLE
- RD_PRE (read address 61), RD_PTN (62), RD_INIT (63), each followed by a one-cycle capture state
- FETCH
- CAPT
- WRITE
- DONE
REQ-014 IDLE -> RD_PRE SHALL occur when Start is sampled 0 and was sampled 1 on the previous cycle.
REQ-015 Preamble captured from address 61 SHALL be clamped: values < 10 become 10, and values > 26 become 26.
REQ-016 Tap pattern SHALL be selected from the byte p at address 62: index = 8 if p == 8, otherwise p[2:0].
- Tap table: 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B.
REQ-017 LFSR state SHALL load the byte at address 63, bits [6:0]. If that value is 0, it SHALL load 7'h01.
REQ-018 Byte loop, index i = 0..63, with k = i - preamble:
- If 0 <= k <= 53: FETCH reads address k; CAPT latches Mem_RData as m.
- Otherwise: m = 0x20, and FETCH/CAPT are skipped.
REQ-019 WRITE SHALL store c to address 64+i, where:
- c[6:0] = m[6:0] ^ lfsr;
- c[7] = XOR-reduce of c[6:0] (m[7] is discarded).
REQ-020 After each accepted write, lfsr SHALL advance to {lfsr[5:0], ^(lfsr & taps)} and i SHALL increment. When i == 63 is written, the FSM SHALL go to DONE; i does not wrap.
REQ-021 With no stalls, each byte SHALL take 3 cycles (read byte) or 1 cycle (pad byte).
REQ-022 DONE SHALL hold Ack=1 until Start is sampled 1, then return to IDLE with Ack=0.
REQ-023 A Start transition during a run SHALL be ignored.
REQ-024 Mem_We SHALL be 1 only in WRITE.

Reset
REQ-025 Reset=0 SHALL immediately force:
- state = IDLE;
- Ack, Busy, Mem_Req, Mem_We = 0;
- Mem_Addr and Mem_WData = 0;
- lfsr = 7'h01, i = 0, preamble = 10, taps = 0x60.
REQ-026 Reset asserted mid-run SHALL abort the run with no further memory writes. A new run SHALL require a fresh Start 1->0 after reset release.

Structure
REQ-027 Shared package enc_pkg SHALL hold:
- the 9-entry tap table;
- address constants: PRE=61, PTN=62, INIT=63, OUT_BASE=64;
- MSG_MAX=54, PRE_MIN=10, PRE_MAX=26;
- the FSM state enum.
REQ-028 The LFSR next-state/parity function SHALL be one sub-module, lfsr7_step (combinational, 7-bit state and taps in, next state out).

Verification
REQ-029 Scenario 1: DM[61]=10, DM[62]=0, DM[63]=0x01, DM[0..60]=0x20, Mem_Gnt=1 -> DM[64]=0x21, DM[65]=0x22, and Ack rises.
REQ-030 Scenario 2: DM[61]=3 -> first message read occurs at i=10. DM[61]=40 -> message starts at i=26. Both match the reference model over all 64 bytes.
REQ-031 Scenario 3: DM[62]=8 selects taps 0x7B. DM[62]=0x0D selects index 5 (0x69). DM[63]=0x00 behaves as 0x01.
REQ-032 Scenario 4: Mem_Gnt toggled pseudo-randomly (about 50% low) -> output identical to the no-stall run, and request signals stay stable during every stall.
REQ-033 Scenario 5: Reset pulsed low at i=20 -> no writes after reset, outputs at reset values, and the next Start 1->0 produces a full correct run.
REQ-034 Scenario 6: message "Ajok" with DM[61]=26 and random pattern/seed -> score 64/64 against the model, Ack held until Start=1.
